// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) support.
// Optional stall/bubble performance counters are enabled by defining ID_EX_PERF_COUNT_EN.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc_plus4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm_ext,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_branch,
  input  logic [ALUOP_W-1:0] id_alu_op,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm_ext,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic               ex_branch,
  output logic [ALUOP_W-1:0] ex_alu_op
`ifdef ID_EX_PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  localparam int unsigned CtrlW = 7 + ALUOP_W;

  logic [CtrlW-1:0] ctrl_in;
  logic [CtrlW-1:0] ctrl_gated;

  // An invalid ID slot must never carry live control bits into EX.
  always_comb begin
    ctrl_in    = {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                  id_alu_src, id_reg_dst, id_branch, id_alu_op};
    ctrl_gated = id_valid ? ctrl_in : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
       ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op} <= '0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
       ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op} <= '0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm_ext    <= id_imm_ext;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
       ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op} <= ctrl_gated;
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  logic stall_evt;
  logic bubble_evt;

  always_comb begin
    stall_evt  = stall && !flush;
    bubble_evt = flush || (!stall && !id_valid);
  end

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bubble_evt && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; counter checks run only when
// ID_EX_PERF_COUNT_EN is defined.
module tb_id_ex_pipe_reg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall, flush, id_valid;
  logic [DATA_W-1:0]  id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
  logic               id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic               id_alu_src, id_reg_dst, id_branch;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [REG_AW-1:0]  ex_rs, ex_rt, ex_rd;
  logic               ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic               ex_alu_src, ex_reg_dst, ex_branch;
  logic [ALUOP_W-1:0] ex_alu_op;
`ifdef ID_EX_PERF_COUNT_EN
  logic [CNT_W-1:0]   stall_cnt, bubble_cnt;
  logic [CNT_W-1:0]   bubble_before;
`endif

  logic [DATA_W*4+REG_AW*3+7+ALUOP_W:0] all_out;
  logic [7+ALUOP_W-1:0]                 ctrl_out;

  assign ctrl_out = {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                     ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op};
  assign all_out  = {ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
                     ex_rs, ex_rt, ex_rd, ctrl_out};

  int npass  = 0;
  int ntotal = 0;

  id_ex_pipe_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .ALUOP_W(ALUOP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_pc_plus4  (id_pc_plus4),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm_ext   (id_imm_ext),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_alu_src   (id_alu_src),
    .id_reg_dst   (id_reg_dst),
    .id_branch    (id_branch),
    .id_alu_op    (id_alu_op),
    .ex_valid     (ex_valid),
    .ex_pc_plus4  (ex_pc_plus4),
    .ex_rs_data   (ex_rs_data),
    .ex_rt_data   (ex_rt_data),
    .ex_imm_ext   (ex_imm_ext),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_alu_src   (ex_alu_src),
    .ex_reg_dst   (ex_reg_dst),
    .ex_branch    (ex_branch),
    .ex_alu_op    (ex_alu_op)
`ifdef ID_EX_PERF_COUNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch, alu_op}
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [10:0] ctrl);
    id_valid    = v;
    id_pc_plus4 = pc;
    id_rs_data  = rsd;
    id_rt_data  = rtd;
    id_imm_ext  = imm;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
     id_alu_src, id_reg_dst, id_branch, id_alu_op} = ctrl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 32'h4, 32'h11, 32'h22, 32'h0000FFFF, 5'd1, 5'd2, 5'd3, 11'h7F2);
    #1;
    ntotal++;
    if (all_out !== '0) $display("FAIL reset_initial: got %h want 0", all_out);
    else npass++;
    @(negedge clk) rst_n = 1'b1;
    step();
    ntotal++;
    if (ex_valid !== 1'b1 || ex_imm_ext !== 32'h0000FFFF)
      $display("FAIL reset_preload: got valid=%b imm=%h want 1/0000ffff", ex_valid, ex_imm_ext);
    else npass++;
    #2 rst_n = 1'b0;
    #1;
    ntotal++;
    if (all_out !== '0) $display("FAIL reset_async: got %h want 0", all_out);
    else npass++;
`ifdef ID_EX_PERF_COUNT_EN
    ntotal++;
    if (stall_cnt !== '0 || bubble_cnt !== '0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    else npass++;
`endif
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_load();
    set_id(1'b1, 32'h100, 32'hAAAA0001, 32'hBBBB0002, 32'h00001234, 5'd9, 5'd5, 5'd12,
           {7'b1000000, 4'h2});
    step();
    ntotal++;
    if (ex_imm_ext !== 32'h00001234 || ex_rt !== 5'd5 || ex_reg_write !== 1'b1 ||
        ex_alu_op !== 4'h2 || ex_valid !== 1'b1)
      $display("FAIL load_main: got imm=%h rt=%0d rw=%b op=%h v=%b want 00001234 5 1 2 1",
               ex_imm_ext, ex_rt, ex_reg_write, ex_alu_op, ex_valid);
    else npass++;
    ntotal++;
    if (ex_pc_plus4 !== 32'h100 || ex_rs_data !== 32'hAAAA0001 || ex_rt_data !== 32'hBBBB0002 ||
        ex_rs !== 5'd9 || ex_rd !== 5'd12 || ctrl_out !== {7'b1000000, 4'h2})
      $display("FAIL load_fields: got pc=%h rsd=%h rtd=%h rs=%0d rd=%0d ctrl=%h", ex_pc_plus4,
               ex_rs_data, ex_rt_data, ex_rs, ex_rd, ctrl_out);
    else npass++;
  endtask

  task automatic test_stall();
    set_id(1'b1, 32'h104, 32'h1, 32'h2, 32'h0000ABCD, 5'd1, 5'd6, 5'd2, {7'b0110100, 4'h7});
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ntotal++;
      if (ex_imm_ext !== 32'h00001234 || ex_valid !== 1'b1 || ex_rt !== 5'd5 ||
          ctrl_out !== {7'b1000000, 4'h2})
        $display("FAIL stall_hold%0d: got imm=%h v=%b rt=%0d ctrl=%h want 00001234 1 5 402",
                 i, ex_imm_ext, ex_valid, ex_rt, ctrl_out);
      else npass++;
    end
`ifdef ID_EX_PERF_COUNT_EN
    ntotal++;
    if (stall_cnt !== 4'd3) $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    else npass++;
`endif
    stall = 1'b0;
    step();
    ntotal++;
    if (ex_imm_ext !== 32'h0000ABCD || ex_rt !== 5'd6 || ctrl_out !== {7'b0110100, 4'h7})
      $display("FAIL stall_release: got imm=%h rt=%0d ctrl=%h want 0000abcd 6 347",
               ex_imm_ext, ex_rt, ctrl_out);
    else npass++;
  endtask

  task automatic test_flush();
`ifdef ID_EX_PERF_COUNT_EN
    bubble_before = bubble_cnt;
`endif
    stall = 1'b1;
    flush = 1'b1;
    step();
    ntotal++;
    if (all_out !== '0) $display("FAIL flush_bubble: got %h want 0", all_out);
    else npass++;
`ifdef ID_EX_PERF_COUNT_EN
    ntotal++;
    if (bubble_cnt !== bubble_before + 4'd1)
      $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt, bubble_before + 4'd1);
    else npass++;
`endif
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_invalid();
    set_id(1'b0, 32'h200, 32'hDEAD0000, 32'h0000BEEF, 32'h00005A5A, 5'd3, 5'd4, 5'd7,
           {7'b1111111, 4'hF});
    step();
    ntotal++;
    if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_reg_write !== 1'b0 || ctrl_out !== '0)
      $display("FAIL invalid_ctrl: got v=%b mw=%b rw=%b ctrl=%h want 0 0 0 0",
               ex_valid, ex_mem_write, ex_reg_write, ctrl_out);
    else npass++;
    ntotal++;
    if (ex_imm_ext !== 32'h00005A5A || ex_rd !== 5'd7 || ex_rs_data !== 32'hDEAD0000 ||
        ex_pc_plus4 !== 32'h200)
      $display("FAIL invalid_data: got imm=%h rd=%0d rsd=%h pc=%h", ex_imm_ext, ex_rd,
               ex_rs_data, ex_pc_plus4);
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms [3];
    logic [10:0] ctls [3];
    imms = '{32'h80000000, 32'hFFFF8001, 32'h0000007F};
    ctls = '{{7'b0010010, 4'h1}, {7'b0001100, 4'h0}, {7'b0000001, 4'h6}};
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h300 + 32'(4 * i), 32'(i), 32'(i + 10), imms[i], 5'(i), 5'(i + 1),
             5'(i + 20), ctls[i]);
      step();
      ntotal++;
      if (ex_valid !== 1'b1 || ex_imm_ext !== imms[i] || ctrl_out !== ctls[i] ||
          ex_rd !== 5'(i + 20))
        $display("FAIL b2b%0d: got v=%b imm=%h ctrl=%h rd=%0d want 1 %h %h %0d", i, ex_valid,
                 ex_imm_ext, ctrl_out, ex_rd, imms[i], ctls[i], i + 20);
      else npass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    ntotal++;
    if (all_out !== '0) $display("FAIL rst_stall_async: got %h want 0", all_out);
    else npass++;
    @(negedge clk) rst_n = 1'b1;
    step();
    ntotal++;
    if (ex_valid !== 1'b0 || all_out !== '0)
      $display("FAIL rst_stall_empty: got %h want 0", all_out);
    else npass++;
    stall = 1'b0;
    step();
    ntotal++;
    if (ex_valid !== 1'b1 || ex_imm_ext !== 32'h0000007F)
      $display("FAIL rst_stall_load: got v=%b imm=%h want 1 0000007f", ex_valid, ex_imm_ext);
    else npass++;
  endtask

`ifdef ID_EX_PERF_COUNT_EN
  task automatic test_saturation();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    ntotal++;
    if (stall_cnt !== 4'hF) $display("FAIL sat_stall: got %0d want 15", stall_cnt);
    else npass++;
    step();
    ntotal++;
    if (stall_cnt !== 4'hF) $display("FAIL sat_hold: got %0d want 15", stall_cnt);
    else npass++;
    stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef ID_EX_PERF_COUNT_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Pipeline register between the decode (ID) and execute (EX) stages of the five-stage MIPS pipeline. It captures the 32-bit extended immediate produced by the 16→32 extender, both register-file read operands, register specifiers and decoded control bits, and presents them to EX one cycle later. It supports hold (stall) and bubble insertion (flush) driven by the hazard unit.

## Interface
- DATA_W, 32, width of PC, operands and extended immediate
- REG_AW, 5, register specifier width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 32, width of performance counters (only with ID_EX_PERF_COUNT_EN)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all EX-side outputs unchanged
- flush  in  1  load a bubble on the next edge
- id_valid  in  1  ID slot holds a real instruction
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  DATA_W each  PC+4, operands, extended immediate
- id_rs, id_rt, id_rd  in  REG_AW each  register specifiers
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch  in  1 each  control bits
- id_alu_op  in  ALUOP_W  ALU operation
- ex_valid  out  1  EX slot holds a real instruction
- ex_* (one per id_* input above)  out  same widths  registered copies
- stall_cnt, bubble_cnt  out  CNT_W each  performance counters (ID_EX_PERF_COUNT_EN only)

## Operation
- Three-way update per rising edge, priority flush > stall > load.
- Load (no flush, no stall): every ex_* ← id_*; ex_valid ← id_valid. If id_valid=0, all control outputs (reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch, alu_op) load 0 regardless of inputs; data fields load normally.
- Stall (stall=1, flush=0): all outputs hold their current value, including ex_valid.
- Flush (flush=1, any stall): bubble loaded: ex_valid=0, all control outputs 0, all data and specifier outputs 0.
- Bubble invariant: whenever ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=ex_branch=0, so EX/MEM/WB cannot commit state.
- No internal arithmetic on data; widths pass through unmodified; id_imm_ext is stored verbatim (no re-extension).

## Timing
- Latency: exactly 1 cycle ID→EX on a load edge.
- Reset: asserting rst_n=0 immediately (asynchronously) forces every output to 0, including ex_valid and counters; holds while low. First load occurs on the first rising edge with rst_n=1.
- Reset mid-stall or mid-flush: reset wins; after release the register is empty (ex_valid=0) until a load edge.
- stall and flush are sampled only at the rising edge; no combinational path from any input to any output.
- Stall of N cycles holds outputs for N edges; the instruction presented on id_* during the stall is not captured (upstream IF/ID must hold it).

## Configuration
- ID_EX_PERF_COUNT_EN defined: stall_cnt increments on each edge with stall=1 and flush=0; bubble_cnt increments on each edge where ex_valid is loaded 0 (flush, or load with id_valid=0). Both saturate at all-ones (no wrap), reset to 0.
- Not defined: counters and their ports are absent; no other behavioural change.

## Test plan
- Reset: rst_n=0 mid-cycle with ex_valid=1, ex_imm_ext=0x0000FFFF → all outputs 0 immediately, before next edge.
- Load: id_valid=1, id_imm_ext=0x00001234, id_rt=5, id_reg_write=1, id_alu_op=4'h2 → next edge ex_imm_ext=0x00001234, ex_rt=5, ex_reg_write=1, ex_alu_op=2, ex_valid=1.
- Stall: after load above, stall=1 for 3 edges with changed id_* (imm 0x0000ABCD) → outputs remain 0x00001234 set for 3 edges; stall=0 → 0x0000ABCD loads next edge; stall_cnt=3.
- Flush vs stall: stall=1, flush=1 same edge with ex_valid=1 → ex_valid=0, all control and data 0; bubble_cnt+1.
- Invalid input: id_valid=0, id_mem_write=1, id_reg_write=1 → ex_valid=0, ex_mem_write=0, ex_reg_write=0, data fields still captured.
- Counter saturation (with macro, CNT_W=4): 20 stall edges → stall_cnt=15 and holds.
